// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm_pkg
// Shared encodings for the multi-cycle MIPS-subset controller:
//   - opcode / funct values of the supported instructions
//   - next-PC select codes (NPC_SEL_*) and datapath select codes
//   - FSM state encoding (4 bits, also exported on the debug port)
//   - instruction class produced by the decoder
package ctrl_fsm_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Next-PC select
  localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'b00;
  localparam logic [1:0] NPC_SEL_REG_JMP  = 2'b01;
  localparam logic [1:0] NPC_SEL_J_JMP    = 2'b10;
  localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'b11;

  // Register-file destination select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // ALU B-operand select
  localparam logic ALU_SRC_RT  = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  // ALU operation
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_OR     = 2'b10;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b11;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Write-back source
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DCD     = 4'd1,
    S_EXE_R   = 4'd2,
    S_EXE_I   = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_MEM  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_JAL     = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_RALU    = 4'd1,
    CLS_IALU    = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_J       = 4'd6,
    CLS_JR      = 4'd7,
    CLS_JAL     = 4'd8
  } class_e;

  // States in which an instruction retires (PC is written).
  function automatic logic is_final(state_e s);
    return (s == S_WB_ALU) || (s == S_WB_MEM) || (s == S_MEM_WR) ||
           (s == S_BRANCH) || (s == S_JUMP)   || (s == S_JAL);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational instruction decoder. Maps opcode/funct to an
// instruction class (used by the FSM for sequencing) and to the datapath
// selects, which depend only on the instruction word and therefore stay
// constant for as long as the fetch unit holds the word.
// Ports:
//   instruction  in  32  instruction word
//   cls          out 4   instruction class (class_e encoding)
//   reg_dst      out 2   destination register select
//   alu_src      out 1   ALU B-operand select
//   alu_op       out 2   ALU operation
//   ext_op       out 2   immediate extension mode
//   mem_to_reg   out 2   write-back source
module ctrl_decode
  import ctrl_fsm_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [3:0]  cls,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic [1:0]  mem_to_reg
);

  logic [5:0] op;
  logic [5:0] fn;
  class_e     cls_d;
  // Register/immediate fields are consumed by the datapath, not here.
  logic       unused_fields;

  assign op            = instruction[31:26];
  assign fn            = instruction[5:0];
  assign unused_fields = ^instruction[25:6];
  assign cls           = cls_d;

  always_comb begin
    cls_d      = CLS_ILLEGAL;
    reg_dst    = REG_DST_RT;
    alu_src    = ALU_SRC_RT;
    alu_op     = ALU_OP_ADD;
    ext_op     = EXT_ZERO;
    mem_to_reg = MEM_TO_REG_ALU;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: begin
            cls_d   = CLS_RALU;
            reg_dst = REG_DST_RD;
            alu_op  = ALU_OP_ADD;
          end
          FN_SUBU: begin
            cls_d   = CLS_RALU;
            reg_dst = REG_DST_RD;
            alu_op  = ALU_OP_SUB;
          end
          FN_JR:   cls_d = CLS_JR;
          default: cls_d = CLS_ILLEGAL;
        endcase
      end
      OP_ORI: begin
        cls_d   = CLS_IALU;
        alu_src = ALU_SRC_IMM;
        alu_op  = ALU_OP_OR;
        ext_op  = EXT_ZERO;
      end
      OP_LUI: begin
        cls_d   = CLS_IALU;
        alu_src = ALU_SRC_IMM;
        alu_op  = ALU_OP_PASS_B;
        ext_op  = EXT_UPPER;
      end
      OP_LW: begin
        cls_d      = CLS_LOAD;
        alu_src    = ALU_SRC_IMM;
        alu_op     = ALU_OP_ADD;
        ext_op     = EXT_SIGN;
        mem_to_reg = MEM_TO_REG_MEM;
      end
      OP_SW: begin
        cls_d   = CLS_STORE;
        alu_src = ALU_SRC_IMM;
        alu_op  = ALU_OP_ADD;
        ext_op  = EXT_SIGN;
      end
      OP_BEQ: begin
        cls_d   = CLS_BRANCH;
        alu_src = ALU_SRC_RT;
        alu_op  = ALU_OP_SUB;
      end
      OP_J:    cls_d = CLS_J;
      OP_JAL: begin
        cls_d      = CLS_JAL;
        reg_dst    = REG_DST_RA;
        mem_to_reg = MEM_TO_REG_PC4;
      end
      default: cls_d = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm
// Multi-cycle controller for a MIPS subset. Holds the state register and
// generates the strobes; datapath selects come from ctrl_decode and are
// passed through from DCD to the final state of each instruction.
// Parameters:
//   ILLEGAL_AS_NOP  1: unsupported encodings retire as a no-op (PC+4)
//                   0: unsupported encodings park the FSM (PC held)
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   instruction  in  32  instruction word, stable while PCWr=0
//   zero         in  1   ALU equality flag (used in BRANCH)
//   PCWr         out 1   PC write strobe
//   NPCSel       out 2   next-PC select
//   RegWr        out 1   register-file write enable
//   RegDst       out 2   destination register select
//   ALUSrc       out 1   ALU B-operand select
//   ALUOp        out 2   ALU operation
//   ExtOp        out 2   immediate extension mode
//   MemWr        out 1   data-memory write enable
//   MemToReg     out 2   write-back source
//   done         out 1   retire pulse
//   illegal      out 1   unsupported-encoding pulse (in DCD)
//   state        out 4   current state, for debug
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int ILLEGAL_AS_NOP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic        PCWr,
  output logic [1:0]  NPCSel,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ExtOp,
  output logic        MemWr,
  output logic [1:0]  MemToReg,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  state
);

  state_e     state_reg;
  class_e     cls;
  logic [3:0] cls_raw;
  logic [1:0] dec_reg_dst;
  logic       dec_alu_src;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_ext_op;
  logic [1:0] dec_mem_to_reg;

  ctrl_decode u_decode (
    .instruction (instruction),
    .cls         (cls_raw),
    .reg_dst     (dec_reg_dst),
    .alu_src     (dec_alu_src),
    .alu_op      (dec_alu_op),
    .ext_op      (dec_ext_op),
    .mem_to_reg  (dec_mem_to_reg)
  );

  assign cls   = class_e'(cls_raw);
  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH: state_reg <= S_DCD;
        S_DCD: begin
          case (cls)
            CLS_RALU:             state_reg <= S_EXE_R;
            CLS_IALU:             state_reg <= S_EXE_I;
            CLS_LOAD, CLS_STORE:  state_reg <= S_MEM_ADR;
            CLS_BRANCH:           state_reg <= S_BRANCH;
            CLS_J, CLS_JR:        state_reg <= S_JUMP;
            CLS_JAL:              state_reg <= S_JAL;
            // Illegal: both modes go back to FETCH; only the PC strobe
            // differs, so the parked mode simply re-decodes the same word.
            default:              state_reg <= S_FETCH;
          endcase
        end
        S_EXE_R, S_EXE_I: state_reg <= S_WB_ALU;
        S_MEM_ADR: state_reg <= (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  state_reg <= S_WB_MEM;
        default:   state_reg <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the registered state and the held instruction.
  // Reset masks everything so an aborted instruction cannot write anything
  // during the reset cycle itself.
  always_comb begin
    PCWr     = 1'b0;
    NPCSel   = NPC_SEL_PC_ADD_4;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    RegDst   = REG_DST_RT;
    ALUSrc   = ALU_SRC_RT;
    ALUOp    = ALU_OP_ADD;
    ExtOp    = EXT_ZERO;
    MemToReg = MEM_TO_REG_ALU;
    if (!reset) begin
      // The word presented in FETCH is not yet decoded; selects stay idle.
      if (state_reg != S_FETCH) begin
        RegDst   = dec_reg_dst;
        ALUSrc   = dec_alu_src;
        ALUOp    = dec_alu_op;
        ExtOp    = dec_ext_op;
        MemToReg = dec_mem_to_reg;
      end
      if (is_final(state_reg)) begin
        PCWr = 1'b1;
        done = 1'b1;
      end
      case (state_reg)
        S_DCD: begin
          if (cls == CLS_ILLEGAL) begin
            illegal = 1'b1;
            if (ILLEGAL_AS_NOP != 0) begin
              PCWr = 1'b1;
              done = 1'b1;
            end
          end
        end
        S_WB_ALU, S_WB_MEM: RegWr = 1'b1;
        S_MEM_WR:           MemWr = 1'b1;
        S_BRANCH:           NPCSel = zero ? NPC_SEL_BEQ_JMP : NPC_SEL_PC_ADD_4;
        S_JUMP:             NPCSel = (cls == CLS_JR) ? NPC_SEL_REG_JMP : NPC_SEL_J_JMP;
        S_JAL: begin
          RegWr  = 1'b1;
          NPCSel = NPC_SEL_J_JMP;
        end
        default: ;
      endcase
    end
  end

endmodule
